// File: rtl/rv_imm_pkg.sv
// Shared RV32I immediate-format definitions used by the encode and decode sides.
package rv_imm_pkg;

    // Immediate format select, same encoding as the decode-side ImmSrc.
    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_fmt_e;

    // Representable immediate ranges per format (B and J must also be even).
    localparam int IMM_IS_MIN = -2048;
    localparam int IMM_IS_MAX = 2047;
    localparam int IMM_B_MIN  = -4096;
    localparam int IMM_B_MAX  = 4094;
    localparam int IMM_J_MIN  = -1048576;
    localparam int IMM_J_MAX  = 1048574;

endpackage

// File: rtl/imm_pack.sv
// Combinational RV32I field packer with immediate legality check.
module imm_pack
    import rv_imm_pkg::*;
(
    input  imm_fmt_e    fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        illegal
);

    logic signed [31:0] simm;
    assign simm = imm;

    // Scatter immediate bits into the slots of the selected format and range-check.
    always_comb begin
        instr   = '0;
        illegal = 1'b0;
        unique case (fmt)
            IMM_I: begin
                instr   = {imm[11:0], rs1, funct3, rd, opcode};
                illegal = (simm < IMM_IS_MIN) || (simm > IMM_IS_MAX);
            end
            IMM_S: begin
                instr   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                illegal = (simm < IMM_IS_MIN) || (simm > IMM_IS_MAX);
            end
            IMM_B: begin
                instr   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                illegal = (simm < IMM_B_MIN) || (simm > IMM_B_MAX) || imm[0];
            end
            IMM_J: begin
                instr   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                illegal = (simm < IMM_J_MIN) || (simm > IMM_J_MAX) || imm[0];
            end
            default: begin
                instr   = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Streaming instruction encoder: 2-entry output FIFO, byte-address counter, drop/error tracking.
module imm_encoder
    import rv_imm_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_sticky,
    output logic [7:0]        err_count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    logic [31:0]       pack_instr;
    logic              pack_illegal;
    logic [1:0]        cnt_q;
    logic [31:0]       skid_instr_q;
    logic [ADDR_W-1:0] skid_addr_q;
    logic [ADDR_W-1:0] addr_q;
    logic              accept;
    logic              push;
    logic              pop;

    imm_pack u_pack (
        .fmt     (imm_fmt_e'(in_fmt)),
        .opcode  (in_opcode),
        .funct3  (in_funct3),
        .rd      (in_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .imm     (in_imm),
        .instr   (pack_instr),
        .illegal (pack_illegal)
    );

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign accept    = in_valid && in_ready && !clear;
    assign push      = accept && !pack_illegal;
    assign pop       = out_valid && out_ready;

    // FIFO: out_instr/out_addr form the head entry, skid_* holds the second word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= 2'd0;
            out_instr    <= '0;
            out_addr     <= BASE;
            skid_instr_q <= '0;
            skid_addr_q  <= BASE;
        end else if (clear) begin
            cnt_q     <= 2'd0;
            out_instr <= '0;
            out_addr  <= BASE;
        end else begin
            unique case (cnt_q)
                2'd0: begin
                    if (push) begin
                        out_instr <= pack_instr;
                        out_addr  <= addr_q;
                        cnt_q     <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        out_instr <= pack_instr;
                        out_addr  <= addr_q;
                    end else if (push) begin
                        skid_instr_q <= pack_instr;
                        skid_addr_q  <= addr_q;
                        cnt_q        <= 2'd2;
                    end else if (pop) begin
                        cnt_q <= 2'd0;
                    end
                end
                2'd2: begin
                    // in_ready is low when full, so only a pop can happen here.
                    if (pop) begin
                        out_instr <= skid_instr_q;
                        out_addr  <= skid_addr_q;
                        cnt_q     <= 2'd1;
                    end
                end
                default: cnt_q <= 2'd0;
            endcase
        end
    end

    // Address counter advances only for words actually enqueued; wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= BASE;
        end else if (clear) begin
            addr_q <= BASE;
        end else if (push) begin
            addr_q <= addr_q + ADDR_W'(4);
        end
    end

    // Error tracking for accepted-but-illegal requests; count saturates at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else if (clear) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else if (accept && pack_illegal) begin
            err_sticky <= 1'b1;
            if (err_count != '1) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder (default and 4-bit address instances).
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [9:0]  out_addr;
    logic        err_sticky;
    logic [7:0]  err_count;

    logic        in_ready2;
    logic        out_valid2;
    logic [31:0] out_instr2;
    logic [3:0]  out_addr2;
    logic        err_sticky2;
    logic [7:0]  err_count2;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    always #5 clk = ~clk;

    imm_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err_sticky(err_sticky), .err_count(err_count)
    );

    imm_encoder #(.ADDR_W(4), .BASE_ADDR(0)) dut4 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready2), .in_fmt(in_fmt),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
        .out_addr(out_addr2), .err_sticky(err_sticky2), .err_count(err_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] f, input logic [6:0] op, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm);
        in_fmt = f; in_opcode = op; in_funct3 = f3;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
    endtask

    // Present one request for exactly one clock; caller sits #1 after a rising edge.
    task automatic send(input logic [1:0] f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm);
        set_req(f, op, f3, rd, rs1, rs2, imm);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_fmt = '0; in_opcode = '0; in_funct3 = '0; in_rd = '0;
        in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_addr", 32'(out_addr), 32'h0);
        chk("rst_err_sticky", 32'(err_sticky), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // I, imm=-1
        send(2'b00, 7'b0010011, 3'd0, 5'd5, 5'd6, 5'd0, 32'hFFFF_FFFF);
        chk("i_valid", 32'(out_valid), 32'd1);
        chk("i_instr", out_instr, 32'hFFF3_0293);
        chk("i_addr", 32'(out_addr), 32'h0);
        chk("i_extend", {{20{out_instr[31]}}, out_instr[31:20]}, 32'hFFFF_FFFF);

        // B, imm=-4
        send(2'b10, 7'b1100011, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
        chk("b_instr", out_instr, 32'hFE20_8EE3);
        chk("b_addr", 32'(out_addr), 32'h4);

        // B, imm=3 (odd) is dropped
        send(2'b10, 7'b1100011, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3);
        chk("b_odd_valid", 32'(out_valid), 32'd0);
        chk("b_odd_sticky", 32'(err_sticky), 32'd1);
        chk("b_odd_count", 32'(err_count), 32'd1);

        // J, imm=2048; address did not advance on the drop
        send(2'b11, 7'b1101111, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        chk("j_instr", out_instr, 32'h0010_00EF);
        chk("j_addr", 32'(out_addr), 32'h8);

        // J, imm=1048576 out of range
        send(2'b11, 7'b1101111, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1048576);
        chk("j_big_valid", 32'(out_valid), 32'd0);
        chk("j_big_count", 32'(err_count), 32'd2);

        // Boundary legal values: I 2047, S -2048, B 4094; I 2048 illegal
        send(2'b00, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2047);
        chk("i_max_instr", out_instr, 32'h7FF0_0093);
        chk("i_max_addr", 32'(out_addr), 32'hC);
        send(2'b01, 7'b0100011, 3'd2, 5'd0, 5'd4, 5'd3, 32'hFFFF_F800);
        chk("s_min_instr", out_instr, 32'h8032_2023);
        chk("s_min_addr", 32'(out_addr), 32'h10);
        send(2'b10, 7'b1100011, 3'd0, 5'd0, 5'd0, 5'd0, 32'd4094);
        chk("b_max_instr", out_instr, 32'h7E00_0FE3);
        chk("b_max_addr", 32'(out_addr), 32'h14);
        send(2'b00, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        chk("i_over_valid", 32'(out_valid), 32'd0);
        chk("i_over_count", 32'(err_count), 32'd3);

        // Back-pressure: two words fill the FIFO, third waits
        clear = 1'b1; tick(); clear = 1'b0;
        out_ready = 1'b0;
        send(2'b00, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        send(2'b00, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2);
        chk("bp_full", 32'(in_ready), 32'd0);
        set_req(2'b00, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'd3);
        tick();
        chk("bp_hold_instr", out_instr, 32'h0010_0093);
        chk("bp_hold_addr", 32'(out_addr), 32'h0);
        chk("bp_still_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_w2_instr", out_instr, 32'h0020_0093);
        chk("bp_w2_addr", 32'(out_addr), 32'h4);
        chk("bp_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_w3_instr", out_instr, 32'h0030_0093);
        chk("bp_w3_addr", 32'(out_addr), 32'h8);
        tick();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // clear with two buffered words and a pending request
        out_ready = 1'b0;
        send(2'b00, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'd4096);
        send(2'b00, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        send(2'b00, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'd6);
        chk("clr_pre_count", 32'(err_count), 32'd1);
        set_req(2'b00, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'd7);
        clear = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_valid", 32'(out_valid), 32'd0);
        chk("clr_in_ready", 32'(in_ready), 32'd1);
        chk("clr_addr", 32'(out_addr), 32'h0);
        chk("clr_err_count", 32'(err_count), 32'd0);
        chk("clr_err_sticky", 32'(err_sticky), 32'd0);

        // Address wrap on the 4-bit instance
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(2'b00, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'(i));
            chk($sformatf("wrap4_addr%0d", i), 32'(out_addr2), 32'((i * 4) % 16));
            chk($sformatf("wide_addr%0d", i), 32'(out_addr), 32'(i * 4));
        end

        // Async reset mid-stream
        out_ready = 1'b0;
        send(2'b00, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'd9);
        send(2'b01, 7'b0100011, 3'd0, 5'd0, 5'd0, 5'd0, 32'd5000);
        chk("ar_pre_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_instr", out_instr, 32'h0);
        chk("ar_addr", 32'(out_addr), 32'h0);
        chk("ar_err_sticky", 32'(err_sticky), 32'd0);
        chk("ar_err_count", 32'(err_count), 32'd0);
        chk("ar_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Streaming instruction encoder: packs opcode, register, funct and 32-bit signed immediate fields into a 32-bit RV32I instruction word.
- Uses the same format select as the decode-side immediate extender: I/S/B/J.
- Validates that the immediate is representable and drops illegal requests.
- Emits encoded words with a byte address for instruction-memory preload and self-test generation, so decode/extend can be exercised end to end.

Parameters:
ADDR_W, 10, width of output byte-address counter
BASE_ADDR, 0, address counter value after reset/clear (word aligned)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous; flushes buffer, reloads address, clears error state
in_valid  in  1  request valid
in_ready  out  1  encoder can accept request
in_fmt  in  2  00 I, 01 S, 10 B, 11 J (same encoding as ImmSrcD)
in_opcode  in  7  instr[6:0]
in_funct3  in  3  instr[14:12] (unused for J)
in_rd  in  5  instr[11:7] (I, J only)
in_rs1  in  5  instr[19:15] (I, S, B)
in_rs2  in  5  instr[24:20] (S, B)
in_imm  in  32  signed immediate / byte offset
out_valid  out  1  encoded word valid
out_ready  in  1  consumer accepts word
out_instr  out  32  encoded instruction
out_addr  out  ADDR_W  byte address of out_instr
err_sticky  out  1  set on any dropped request
err_count  out  8  dropped-request count, saturates at 255

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_instr=0, out_addr=BASE_ADDR, err_sticky=0, err_count=0.
  - Buffer empty; in_ready=1 on the first cycle after release.
- Handshakes:
  - Input accepted when in_valid and in_ready.
  - Output transferred when out_valid and out_ready.
  - Inputs are sampled only on acceptance.
- Encoding (combinational from accepted fields):
  - I: imm[11:0] to [31:20].
  - S: imm[11:5] to [31:25], imm[4:0] to [11:7].
  - B: imm[12] to [31], imm[10:5] to [30:25], imm[4:1] to [11:8], imm[11] to [7].
  - J: imm[20] to [31], imm[10:1] to [30:21], imm[11] to [20], imm[19:12] to [19:12].
  - opcode is always placed in [6:0].
  - Unused slots (rd for S/B, rs for J, funct3 for J) come from immediate bits only; the corresponding port is ignored.
- Legality (request is illegal otherwise):
  - I/S: -2048..2047.
  - B: -4096..4094 and imm[0]=0.
  - J: -1048576..1048574 and imm[0]=0.
- Illegal accepted request:
  - Not enqueued; address does not advance.
  - err_sticky set; err_count increments, saturating.
  - Still consumes the handshake, so it is never stalled.
- Latency and buffering:
  - Legal accepted request appears on out_* the next cycle: 1-cycle latency, registered outputs.
  - 2-entry FIFO (output register plus skid entry); in_ready = not full (registered count).
  - Full throughput (1/cycle) while out_ready=1.
  - Words leave in accept order. Simultaneous push and pop when full is not possible (in_ready=0). Simultaneous push and pop at count 1 keeps count 1.
- Address:
  - Each legal enqueued word takes the current address counter, which then increments by 4.
  - Counter wraps modulo 2^ADDR_W with no flag.
  - out_addr travels with its word.
- clear:
  - Highest priority over handshakes that cycle: the request is not accepted, the FIFO is emptied, out_valid=0.
  - Address reloads to BASE_ADDR; err state is zeroed.
- Reset mid-transfer: the buffered words are lost; no partial state survives.
- out_instr holds its value while out_valid=1 and out_ready=0.

Decomposition:
- Shared package rv_imm_pkg holds:
  - The IMM_I/IMM_S/IMM_B/IMM_J 2-bit constants, shared with the decode-side extender.
  - The range-limit constants.
- Sub-module imm_pack: purely combinational field packer plus legality check (fmt, fields, imm -> instr, illegal).
- The top module holds the FIFO, address counter and error logic.

Test Plan:
- I, imm=-1, opcode 0010011, rd=5, rs1=6, funct3=0 -> out_instr 0xFFF30293 at addr 0x000 one cycle after acceptance; feeding it to the extender with ImmSrc=00 returns 0xFFFFFFFF.
- B, imm=-4, rs1=1, rs2=2, funct3=0, opcode 1100011 -> 0xFE208EE3. B, imm=3 -> dropped, err_sticky=1, err_count=1, address unchanged.
- J, imm=2048, rd=1, opcode 1101111 -> 0x001000EF. J, imm=1048576 -> dropped.
- Back-pressure: out_ready=0, push 3 legal words -> in_ready=0 after 2 accepted. Release out_ready -> words drain in order at addrs 0x0, 0x4, then the third is accepted at 0x8.
- ADDR_W=4, 5 legal words -> addrs 0x0, 0x4, 0x8, 0xC, 0x0 (wrap).
- clear asserted with 2 buffered words and in_valid=1 -> next cycle out_valid=0, in_ready=1, out_addr base, err_count=0. Async rst_n pulse mid-stream -> same reset values immediately.
